reg_native_if2apb: RTL and testbench

- Master-side bridge: accepts single-cycle reg native requests (req_vld/wr_en/rd_en/addr/wr_data) from register-access logic and issues one APB3 transfer per request as APB requester.
- Returns ack_vld, rd_data and err to the native side when the transfer completes.
- Sits between generated register-tree upstream logic and an APB-attached slave. It is the counterpart of the APB-to-native slave bridge.
- A programmable timeout terminates transfers against a hung slave.

---
 rtl/reg_bridge_pkg.sv | 15 +
 rtl/reg_native_if2apb_if.sv | 36 +++
 rtl/reg_bridge_timeout_cnt.sv | 32 +++
 rtl/reg_native_if2apb.sv | 135 +++++++++++++
 tb/tb_reg_native_if2apb.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_bridge_pkg.sv
// Shared definitions for the native-to-APB requester bridge.
//   state_e           : bridge FSM state encoding (2-bit)
//   TIMEOUT_DISABLED  : TIMEOUT_CYCLES value that removes the timeout counter
package reg_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

   localparam int TIMEOUT_DISABLED = 0;

endpackage

// File: rtl/reg_native_if2apb_if.sv
// Bus bundle for the native-to-APB bridge: native request/response side plus
// the APB3 requester signals.
//   master : view of the bridge (consumes native requests, drives APB)
//   slave  : view of the environment (issues native requests, answers APB)
interface reg_native_if2apb_if #(
   parameter int ADDR_WIDTH = 48,
   parameter int DATA_WIDTH = 32
);
   logic                  req_vld;
   logic                  wr_en;
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  ack_vld;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  err;

   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_WIDTH-1:0] paddr;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pready;
   logic                  pslverr;

   modport master (
      input  req_vld, wr_en, rd_en, addr, wr_data, prdata, pready, pslverr,
      output ack_vld, rd_data, err, psel, penable, pwrite, paddr, pwdata
   );

   modport slave (
      output req_vld, wr_en, rd_en, addr, wr_data, prdata, pready, pslverr,
      input  ack_vld, rd_data, err, psel, penable, pwrite, paddr, pwdata
   );
endinterface

// File: rtl/reg_bridge_timeout_cnt.sv
// ACCESS-phase wait counter with terminal-count flag.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : synchronous clear (wins over en_i)
//   en_i       : count one wait cycle
//   tc_o       : high while the count equals TERMINAL
module reg_bridge_timeout_cnt #(
   parameter int CNT_WIDTH = 16,
   parameter int TERMINAL  = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);
   localparam logic [CNT_WIDTH-1:0] TC_VAL = CNT_WIDTH'(TERMINAL);

   logic [CNT_WIDTH-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
   end

   assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/reg_native_if2apb.sv
// Native register request to APB3 requester bridge. Each accepted single-cycle
// native request becomes one APB transfer; completion is returned as a
// one-cycle ack_vld with rd_data/err. All bus outputs are flop-driven.
//   clk, rst_n : clock, async active-low reset
//   bus        : native request/response and APB requester signals
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | waiting for req_vld; APB outputs and response held at 0
//   ST_SETUP  | psel=1, penable=0
//   ST_ACCESS | psel=1, penable=1; wait for pready or timeout
//   ST_RESP   | ack_vld=1 for one cycle with rd_data/err
module reg_native_if2apb
   import reg_bridge_pkg::*;
#(
   parameter int ADDR_WIDTH     = 48,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 0,
   // TIMEOUT_CYCLES must stay below 2**CNT_WIDTH
   parameter int CNT_WIDTH      = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   reg_native_if2apb_if.master  bus
);

   state_e                state_q;
   logic                  psel_q;
   logic                  penable_q;
   logic                  pwrite_q;
   logic [ADDR_WIDTH-1:0] paddr_q;
   logic [DATA_WIDTH-1:0] pwdata_q;
   logic                  ack_q;
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic                  err_q;

   logic tmo_tc;
   logic access_done;

   // rd_en only documents intent; direction is decided by wr_en alone
   logic unused_rd_en;
   assign unused_rd_en = bus.rd_en;

   generate
      if (TIMEOUT_CYCLES != TIMEOUT_DISABLED) begin : g_tmo
         logic cnt_clr;
         logic cnt_en;

         assign cnt_clr = (state_q != ST_ACCESS);
         assign cnt_en  = (state_q == ST_ACCESS) && !bus.pready;

         reg_bridge_timeout_cnt #(
            .CNT_WIDTH (CNT_WIDTH),
            .TERMINAL  (TIMEOUT_CYCLES - 1)
         ) u_tmo_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr_i (cnt_clr),
            .en_i  (cnt_en),
            .tc_o  (tmo_tc)
         );
      end else begin : g_no_tmo
         assign tmo_tc = 1'b0;
      end
   endgenerate

   // pready wins over a coincident timeout so a slave answering on the last
   // allowed cycle still completes normally
   assign access_done = bus.pready || tmo_tc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         ack_q     <= 1'b0;
         rd_data_q <= '0;
         err_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               ack_q     <= 1'b0;
               rd_data_q <= '0;
               err_q     <= 1'b0;
               if (bus.req_vld) begin
                  paddr_q  <= bus.addr;
                  pwdata_q <= bus.wr_data;
                  pwrite_q <= bus.wr_en;
                  psel_q   <= 1'b1;
                  state_q  <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               penable_q <= 1'b1;
               state_q   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (access_done) begin
                  rd_data_q <= (bus.pready && !pwrite_q) ? bus.prdata : '0;
                  err_q     <= bus.pready ? bus.pslverr : 1'b1;
                  ack_q     <= 1'b1;
                  psel_q    <= 1'b0;
                  penable_q <= 1'b0;
                  pwrite_q  <= 1'b0;
                  paddr_q   <= '0;
                  pwdata_q  <= '0;
                  state_q   <= ST_RESP;
               end
            end
            ST_RESP: begin
               ack_q     <= 1'b0;
               rd_data_q <= '0;
               err_q     <= 1'b0;
               state_q   <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.psel    = psel_q;
   assign bus.penable = penable_q;
   assign bus.pwrite  = pwrite_q;
   assign bus.paddr   = paddr_q;
   assign bus.pwdata  = pwdata_q;
   assign bus.ack_vld = ack_q;
   assign bus.rd_data = rd_data_q;
   assign bus.err     = err_q;

endmodule

// File: tb/tb_reg_native_if2apb.sv
// Self-checking bench for reg_native_if2apb (TIMEOUT_CYCLES = 4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_reg_native_if2apb;
   localparam int AW = 48;
   localparam int DW = 32;
   localparam int T  = 4;
   localparam int CW = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   reg_native_if2apb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   reg_native_if2apb #(
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (T),
      .CNT_WIDTH      (CW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int   n_cmp = 0;
   int   n_mis = 0;
   logic busy_probe = 1'b0;
   logic outstanding;

   // upstream must not issue a request while one is outstanding
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)           outstanding <= 1'b0;
      else if (bus.ack_vld) outstanding <= 1'b0;
      else if (bus.req_vld) outstanding <= 1'b1;
   end

   a_no_busy_req: assert property (@(posedge clk) disable iff (!rst_n || busy_probe)
      !(bus.req_vld && outstanding))
      else begin
         n_mis++;
         $display("FAIL upstream_busy: req_vld=1 while a request is outstanding");
      end

   typedef struct {
      int            ack_cyc;
      logic [DW-1:0] rd;
      logic          err;
      int            setup_cyc;
      int            nsetup;
      int            nacc;
      int            bad_stab;
      int            bad_idle;
   } obs_t;

   typedef struct {
      int            lat;
      logic [DW-1:0] rd;
      logic          err;
      int            nacc;
   } exp_t;

   // Reference: a slave holding pready low for 'waits' ACCESS cycles
   function automatic exp_t model(input logic wr, input int waits,
                                  input logic slverr, input logic [DW-1:0] prd);
      exp_t e;
      bit   tmo;
      tmo    = (T != 0) && (waits >= T);
      e.lat  = tmo ? 2 + T : 3 + waits;
      e.nacc = tmo ? T : waits + 1;
      e.rd   = (tmo || wr) ? '0 : prd;
      e.err  = tmo ? 1'b1 : slverr;
      return e;
   endfunction

   function automatic logic [AW-1:0] rnd_addr();
      return AW'({$urandom(), $urandom()});
   endfunction

   // One native request plus an APB slave answering after 'waits' cycles.
   // busy_at > 0 injects an extra req_vld in that cycle.
   task automatic xfer(input logic wr, input logic rd, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input int waits, input logic slverr,
                       input logic [DW-1:0] prd, input int busy_at, output obs_t o);
      int acc_idx;
      o.ack_cyc = -1; o.rd = '0; o.err = 1'b0; o.setup_cyc = -1;
      o.nsetup = 0; o.nacc = 0; o.bad_stab = 0; o.bad_idle = 0;
      acc_idx = 0;
      @(negedge clk);
      if (bus.ack_vld || bus.psel) o.bad_idle++;
      bus.req_vld = 1'b1; bus.wr_en = wr; bus.rd_en = rd;
      bus.addr = a; bus.wr_data = d; bus.pready = 1'b0;
      for (int k = 1; k <= 40 && o.ack_cyc < 0; k++) begin
         @(negedge clk);
         if (bus.psel && !bus.penable) begin
            o.nsetup++;
            if (o.setup_cyc < 0) o.setup_cyc = k;
         end
         if (bus.psel && (bus.paddr !== a || bus.pwdata !== d || bus.pwrite !== wr))
            o.bad_stab++;
         if (!bus.psel && !bus.ack_vld &&
             (bus.paddr !== '0 || bus.pwdata !== '0 || bus.pwrite !== 1'b0))
            o.bad_idle++;
         if (!bus.ack_vld && (bus.rd_data !== '0 || bus.err !== 1'b0)) o.bad_idle++;
         if (bus.ack_vld) begin
            o.ack_cyc = k; o.rd = bus.rd_data; o.err = bus.err;
         end
         bus.req_vld = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
         bus.addr = rnd_addr(); bus.wr_data = $urandom();
         if (k == busy_at) begin
            bus.req_vld = 1'b1; bus.wr_en = 1'($urandom()); bus.rd_en = 1'($urandom());
         end
         bus.pready = 1'b0; bus.prdata = $urandom(); bus.pslverr = 1'($urandom());
         if (bus.psel && bus.penable) begin
            o.nacc++;
            if (acc_idx == waits) begin
               bus.pready = 1'b1; bus.prdata = prd; bus.pslverr = slverr;
            end
            acc_idx++;
         end
      end
   endtask

   task automatic test_reset();
      bus.req_vld = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = '0;
      bus.wr_data = '0; bus.prdata = '0; bus.pready = 1'b0; bus.pslverr = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({bus.psel, bus.penable, bus.pwrite, bus.ack_vld, bus.err} !== 5'b0) begin
         n_mis++;
         $display("FAIL reset_ctrl: got %b expected 00000",
                  {bus.psel, bus.penable, bus.pwrite, bus.ack_vld, bus.err});
      end
      n_cmp++;
      if ({bus.paddr, bus.pwdata, bus.rd_data} !== '0) begin
         n_mis++;
         $display("FAIL reset_data: paddr=%h pwdata=%h rd_data=%h expected all 0",
                  bus.paddr, bus.pwdata, bus.rd_data);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_zero_wait_write();
      obs_t o;
      xfer(1'b1, 1'b0, 48'h1000, 32'hDEADBEEF, 0, 1'b0, $urandom(), -1, o);
      n_cmp++; if (o.setup_cyc !== 1) begin n_mis++; $display("FAIL zw_setup_cycle: got %0d expected 1", o.setup_cyc); end
      n_cmp++; if (o.ack_cyc !== 3) begin n_mis++; $display("FAIL zw_ack_cycle: got %0d expected 3", o.ack_cyc); end
      n_cmp++; if (o.nacc !== 1) begin n_mis++; $display("FAIL zw_access_cycles: got %0d expected 1", o.nacc); end
      n_cmp++; if (o.rd !== '0 || o.err !== 1'b0) begin n_mis++; $display("FAIL zw_resp: rd=%h err=%b expected 0/0", o.rd, o.err); end
      n_cmp++; if (o.bad_stab !== 0) begin n_mis++; $display("FAIL zw_apb_fields: %0d bad cycles expected 0", o.bad_stab); end
   endtask

   task automatic test_wait_read();
      obs_t o;
      xfer(1'b0, 1'b1, 48'h24, $urandom(), 3, 1'b0, 32'h12345678, -1, o);
      n_cmp++; if (o.ack_cyc !== 6) begin n_mis++; $display("FAIL wr_ack_cycle: got %0d expected 6", o.ack_cyc); end
      n_cmp++; if (o.rd !== 32'h12345678) begin n_mis++; $display("FAIL wr_rd_data: got %h expected 12345678", o.rd); end
      n_cmp++; if (o.err !== 1'b0) begin n_mis++; $display("FAIL wr_err: got %b expected 0", o.err); end
      n_cmp++; if (o.bad_stab !== 0) begin n_mis++; $display("FAIL wr_paddr_stable: %0d bad cycles expected 0", o.bad_stab); end
   endtask

   task automatic test_slave_error();
      obs_t          o;
      logic [DW-1:0] prd;
      xfer(1'b1, 1'b1, rnd_addr(), $urandom(), 1, 1'b1, $urandom(), -1, o);
      n_cmp++; if (o.ack_cyc !== 4) begin n_mis++; $display("FAIL se_ack_cycle: got %0d expected 4", o.ack_cyc); end
      n_cmp++; if (o.err !== 1'b1 || o.rd !== '0) begin n_mis++; $display("FAIL se_write_resp: err=%b rd=%h expected 1/0", o.err, o.rd); end
      prd = $urandom();
      xfer(1'b0, 1'b0, rnd_addr(), $urandom(), 0, 1'b1, prd, -1, o);
      n_cmp++; if (o.err !== 1'b1 || o.rd !== prd) begin n_mis++; $display("FAIL se_read_resp: err=%b rd=%h expected 1/%h", o.err, o.rd, prd); end
   endtask

   task automatic test_timeout();
      obs_t          o;
      logic [DW-1:0] prd;
      xfer(1'b0, 1'b1, rnd_addr(), $urandom(), 1000, 1'b0, $urandom(), -1, o);
      n_cmp++; if (o.nacc !== T) begin n_mis++; $display("FAIL to_access_cycles: got %0d expected %0d", o.nacc, T); end
      n_cmp++; if (o.ack_cyc !== 2 + T) begin n_mis++; $display("FAIL to_ack_cycle: got %0d expected %0d", o.ack_cyc, 2 + T); end
      n_cmp++; if (o.err !== 1'b1 || o.rd !== '0) begin n_mis++; $display("FAIL to_resp: err=%b rd=%h expected 1/0", o.err, o.rd); end
      prd = $urandom();
      xfer(1'b0, 1'b1, rnd_addr(), $urandom(), T - 1, 1'b0, prd, -1, o);
      n_cmp++; if (o.ack_cyc !== T + 2) begin n_mis++; $display("FAIL to_edge_ack_cycle: got %0d expected %0d", o.ack_cyc, T + 2); end
      n_cmp++; if (o.err !== 1'b0 || o.rd !== prd) begin n_mis++; $display("FAIL to_edge_resp: err=%b rd=%h expected 0/%h", o.err, o.rd, prd); end
   endtask

   task automatic test_busy();
      obs_t o;
      busy_probe = 1'b1;
      xfer(1'b1, 1'b0, rnd_addr(), $urandom(), 2, 1'b0, $urandom(), 3, o);
      n_cmp++; if (o.nsetup !== 1) begin n_mis++; $display("FAIL busy_access_setups: got %0d expected 1", o.nsetup); end
      n_cmp++; if (o.bad_stab !== 0) begin n_mis++; $display("FAIL busy_access_fields: %0d bad cycles expected 0", o.bad_stab); end
      n_cmp++; if (o.ack_cyc !== 5) begin n_mis++; $display("FAIL busy_access_ack: got %0d expected 5", o.ack_cyc); end
      // extra request lands in the RESP cycle
      xfer(1'b0, 1'b0, rnd_addr(), $urandom(), 0, 1'b0, $urandom(), 3, o);
      @(negedge clk);
      bus.req_vld = 1'b0;
      n_cmp++; if (bus.psel !== 1'b0) begin n_mis++; $display("FAIL busy_resp_ignored: psel=%b expected 0", bus.psel); end
      busy_probe = 1'b0;
   endtask

   task automatic test_back_to_back();
      obs_t          o;
      exp_t          e;
      logic          wr;
      int            w;
      logic          se;
      logic [DW-1:0] prd;
      for (int i = 0; i < 4; i++) begin
         wr = 1'($urandom()); w = $urandom_range(0, 2); se = 1'($urandom()); prd = $urandom();
         e = model(wr, w, se, prd);
         xfer(wr, ~wr, rnd_addr(), $urandom(), w, se, prd, -1, o);
         n_cmp++; if (o.setup_cyc !== 1) begin n_mis++; $display("FAIL b2b_setup_cycle[%0d]: got %0d expected 1", i, o.setup_cyc); end
         n_cmp++; if (o.ack_cyc !== e.lat) begin n_mis++; $display("FAIL b2b_ack_cycle[%0d]: got %0d expected %0d", i, o.ack_cyc, e.lat); end
         n_cmp++; if (o.rd !== e.rd || o.err !== e.err) begin n_mis++; $display("FAIL b2b_resp[%0d]: rd=%h err=%b expected %h/%b", i, o.rd, o.err, e.rd, e.err); end
         n_cmp++; if (o.bad_idle !== 0) begin n_mis++; $display("FAIL b2b_idle_outputs[%0d]: %0d bad cycles expected 0", i, o.bad_idle); end
      end
   endtask

   task automatic test_random();
      obs_t          o;
      exp_t          e;
      logic          wr;
      logic          rd;
      int            w;
      logic          se;
      logic [DW-1:0] prd;
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         wr = 1'($urandom()); rd = 1'($urandom()); w = $urandom_range(0, T + 1);
         se = 1'($urandom()); prd = $urandom();
         e = model(wr, w, se, prd);
         xfer(wr, rd, rnd_addr(), $urandom(), w, se, prd, -1, o);
         n_cmp++; if (o.ack_cyc !== e.lat) begin n_mis++; $display("FAIL rnd_ack_cycle[%0d]: got %0d expected %0d", i, o.ack_cyc, e.lat); end
         n_cmp++; if (o.rd !== e.rd) begin n_mis++; $display("FAIL rnd_rd_data[%0d]: got %h expected %h", i, o.rd, e.rd); end
         n_cmp++; if (o.err !== e.err) begin n_mis++; $display("FAIL rnd_err[%0d]: got %b expected %b", i, o.err, e.err); end
         n_cmp++; if (o.nacc !== e.nacc) begin n_mis++; $display("FAIL rnd_access_cycles[%0d]: got %0d expected %0d", i, o.nacc, e.nacc); end
         n_cmp++; if (o.nsetup !== 1) begin n_mis++; $display("FAIL rnd_setups[%0d]: got %0d expected 1", i, o.nsetup); end
         n_cmp++; if (o.bad_stab !== 0 || o.bad_idle !== 0) begin n_mis++; $display("FAIL rnd_output_rules[%0d]: stab=%0d idle=%0d expected 0/0", i, o.bad_stab, o.bad_idle); end
      end
   endtask

   task automatic test_reset_mid();
      obs_t          o;
      int            seen;
      logic [DW-1:0] prd;
      @(negedge clk);
      bus.req_vld = 1'b1; bus.wr_en = 1'b0; bus.rd_en = 1'b1; bus.addr = rnd_addr();
      bus.pready = 1'b0;
      @(negedge clk);
      bus.req_vld = 1'b0; bus.rd_en = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if ({bus.psel, bus.penable} !== 2'b11) begin n_mis++; $display("FAIL rm_in_access: psel/penable=%b expected 11", {bus.psel, bus.penable}); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({bus.psel, bus.penable, bus.ack_vld} !== 3'b000) begin n_mis++; $display("FAIL rm_async_drop: psel/penable/ack=%b expected 000", {bus.psel, bus.penable, bus.ack_vld}); end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.ack_vld || bus.psel) seen++;
      end
      n_cmp++; if (seen !== 0) begin n_mis++; $display("FAIL rm_no_ack_after: %0d busy cycles expected 0", seen); end
      prd = $urandom();
      xfer(1'b0, 1'b1, rnd_addr(), $urandom(), 1, 1'b0, prd, -1, o);
      n_cmp++; if (o.ack_cyc !== 4 || o.rd !== prd || o.err !== 1'b0) begin n_mis++; $display("FAIL rm_next_xfer: ack=%0d rd=%h err=%b expected 4/%h/0", o.ack_cyc, o.rd, o.err, prd); end
   endtask

   initial begin
      test_reset();
      test_zero_wait_write();
      test_wait_read();
      test_slave_error();
      test_timeout();
      test_busy();
      test_back_to_back();
      test_random();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "watchdog expired");
   end

endmodule
